// File: rtl/neureka_streamout_packer_if.sv
// hwpe_stream_intf_stream: valid/ready stream with per-byte strobe, used on both
// the engine side and the streamer side of the store-out packer.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 256
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/neureka_streamout_packer.sv
// neureka_streamout_packer: compacts nb_bytes-wide store_out beats into full stream words.
// Optional NEUREKA_PACKER_STATS_EN enables full/partial output beat counters on stats_o.
module neureka_streamout_packer #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clear_i,
  input  logic                           start_i,
  input  logic [$clog2(DATA_WIDTH/8):0]  nb_bytes_i,
  input  logic [CNT_WIDTH-1:0]           nb_words_i,
  hwpe_stream_intf_stream.sink           push_i,
  hwpe_stream_intf_stream.source         pop_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [63:0]                    stats_o
);

  localparam int unsigned BYTES  = DATA_WIDTH / 8;
  localparam int unsigned NB_W   = $clog2(BYTES) + 1;
  localparam int unsigned FILL_W = $clog2(2 * BYTES);
  localparam int unsigned BUF_W  = (2 * BYTES - 1) * 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e               state_r, state_next_s;
  logic [FILL_W-1:0]    fill_r, fill_next_s, base_s, pop_sub_s;
  logic [BUF_W-1:0]     buf_r, buf_next_s;
  logic [NB_W-1:0]      nb_r, nb_sel_s;
  logic [CNT_WIDTH-1:0] rem_r;
  logic                 valid_r, valid_next_s;
  logic [BYTES-1:0]     strb_r, strb_next_s;
  logic                 busy_r, done_r;
  logic                 push_ready_s, push_hs_s, pop_hs_s, start_s;
  logic                 unused_s;

  function automatic logic [DATA_WIDTH-1:0] byte_mask(input logic [NB_W-1:0] n);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < int'(BYTES); i++) begin
      m[i*8 +: 8] = (i < int'(n)) ? 8'hFF : 8'h00;
    end
    return m;
  endfunction

  function automatic logic [BYTES-1:0] strb_mask(input logic [FILL_W-1:0] f);
    logic [BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < int'(BYTES); i++) begin
      m[i] = (i < int'(f));
    end
    return m;
  endfunction

  assign start_s      = (state_r == IDLE) && start_i;
  assign nb_sel_s     = ((nb_bytes_i == NB_W'(0)) || (nb_bytes_i > NB_W'(BYTES))) ? NB_W'(BYTES) : nb_bytes_i;
  assign push_ready_s = (state_r == RUN) && ((fill_r < FILL_W'(BYTES)) || pop_o.ready);
  assign push_hs_s    = push_i.valid && push_ready_s;
  assign pop_hs_s     = valid_r && pop_o.ready;
  assign unused_s     = ^push_i.strb;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else if (clear_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; an empty tile drains through FLUSH so done lands two cycles after start
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          state_next_s = (nb_words_i == CNT_WIDTH'(0)) ? FLUSH : RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (push_hs_s && (rem_r == CNT_WIDTH'(1))) begin
          state_next_s = FLUSH;
        end else begin
          state_next_s = RUN;
        end
      end
      FLUSH: begin
        if (fill_next_s == FILL_W'(0)) begin
          state_next_s = DONE;
        end else begin
          state_next_s = FLUSH;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Buffer shift/insert: incoming bytes land after the pop shift, bytes above fill stay zero
  always_comb begin
    pop_sub_s  = (fill_r >= FILL_W'(BYTES)) ? FILL_W'(BYTES) : fill_r;
    base_s     = pop_hs_s ? (fill_r - pop_sub_s) : fill_r;
    buf_next_s = pop_hs_s ? (buf_r >> DATA_WIDTH) : buf_r;
    if (push_hs_s) begin
      buf_next_s  = buf_next_s | (BUF_W'(push_i.data & byte_mask(nb_r)) << {base_s, 3'b000});
      fill_next_s = base_s + FILL_W'(nb_r);
    end else begin
      fill_next_s = base_s;
    end
  end

  // Output qualifiers derived from the post-update fill level
  always_comb begin
    valid_next_s = ((state_next_s == RUN) && (fill_next_s >= FILL_W'(BYTES))) ||
                   ((state_next_s == FLUSH) && (fill_next_s != FILL_W'(0)));
    if (valid_next_s) begin
      strb_next_s = strb_mask(fill_next_s);
    end else begin
      strb_next_s = '0;
    end
  end

  // Datapath registers and registered status outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fill_r  <= '0;
      buf_r   <= '0;
      nb_r    <= '0;
      rem_r   <= '0;
      valid_r <= 1'b0;
      strb_r  <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (clear_i) begin
      fill_r  <= '0;
      buf_r   <= '0;
      nb_r    <= '0;
      rem_r   <= '0;
      valid_r <= 1'b0;
      strb_r  <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      if (start_s) begin
        fill_r <= '0;
        buf_r  <= '0;
        nb_r   <= nb_sel_s;
        rem_r  <= nb_words_i;
      end else begin
        fill_r <= fill_next_s;
        buf_r  <= buf_next_s;
        if (push_hs_s) begin
          rem_r <= rem_r - CNT_WIDTH'(1);
        end
      end
      valid_r <= valid_next_s;
      strb_r  <= strb_next_s;
      busy_r  <= (state_next_s == RUN) || (state_next_s == FLUSH);
      done_r  <= (state_next_s == DONE);
    end
  end

`ifdef NEUREKA_PACKER_STATS_EN
  logic [31:0] full_cnt_r, part_cnt_r;

  // Cumulative output-beat counters, split by full or partial strobe
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_cnt_r <= 32'd0;
      part_cnt_r <= 32'd0;
    end else if (clear_i) begin
      full_cnt_r <= 32'd0;
      part_cnt_r <= 32'd0;
    end else if (pop_hs_s) begin
      if (&strb_r) begin
        full_cnt_r <= full_cnt_r + 32'd1;
      end else begin
        part_cnt_r <= part_cnt_r + 32'd1;
      end
    end
  end

  assign stats_o = {part_cnt_r, full_cnt_r};
`else
  assign stats_o = 64'd0;
`endif

  assign push_i.ready = push_ready_s;
  assign pop_o.valid  = valid_r;
  assign pop_o.data   = buf_r[DATA_WIDTH-1:0];
  assign pop_o.strb   = strb_r;
  assign busy_o       = busy_r;
  assign done_o       = done_r;

endmodule

// File: tb/tb_neureka_streamout_packer.sv
// Scoreboard bench for neureka_streamout_packer: byte-stream reference model, random
// stimulus and backpressure, with a monitor checking every output handshake.
module tb_neureka_streamout_packer;
  localparam int DW = 256;
  localparam int NB = DW / 8;

  typedef struct {
    logic [DW-1:0] data;
    logic [NB-1:0] strb;
    bit            last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_ni, clear_i, start_i;
  logic [5:0]  nb_bytes_i;
  logic [15:0] nb_words_i;
  logic        busy_o, done_o;
  logic [63:0] stats_o;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) push_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) pop_if ();

  neureka_streamout_packer #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .start_i    (start_i),
    .nb_bytes_i (nb_bytes_i),
    .nb_words_i (nb_words_i),
    .push_i     (push_if),
    .pop_o      (pop_if),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .stats_o    (stats_o)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   cycle_cnt = 0;
  bit   rdy_rand = 1'b0;
  bit   mon_en = 1'b0;
  exp_t sb[$];

  // monitor-side model state
  int            mfill, mleft, mnb, done_in;
  bit            busy_exp, prev_stall, after_clr;
  logic [DW-1:0] prev_data;
  logic [NB-1:0] prev_strb;
  logic [31:0]   full_cnt, part_cnt;
  logic [63:0]   exp_stats;
  exp_t          mon_e;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int eff_nb(input int n);
    return (n == 0 || n > NB) ? NB : n;
  endfunction

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  initial begin
    pop_if.ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pop_if.ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: checks handshakes, ready/busy/done/stats each cycle against the model
  always @(negedge clk) begin
    if (mon_en) begin
`ifdef NEUREKA_PACKER_STATS_EN
      exp_stats = {part_cnt, full_cnt};
`else
      exp_stats = 64'd0;
`endif
      chk("done_o", done_o, done_in == 1);
      chk("busy_o", busy_o, busy_exp);
      chk("push_ready", push_if.ready, busy_exp && mleft > 0 && (mfill < NB || pop_if.ready));
      chk("stats_o", stats_o, exp_stats);
      if (after_clr) chk("valid_after_clear", pop_if.valid, 1'b0);
      if (prev_stall) begin
        chk("stall_valid", pop_if.valid, 1'b1);
        chk("stall_data", pop_if.data, prev_data);
        chk("stall_strb", pop_if.strb, prev_strb);
      end
      if (done_in > 0) done_in--;
      after_clr = 1'b0;
      if (pop_if.valid && pop_if.ready) begin
        chk("pop_expected", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("pop_data", pop_if.data, mon_e.data);
          chk("pop_strb", pop_if.strb, mon_e.strb);
          if (&mon_e.strb) full_cnt++;
          else part_cnt++;
          if (mon_e.last) done_in = 1;
        end
        mfill = (mfill >= NB) ? mfill - NB : 0;
      end
      if (push_if.valid && push_if.ready) begin
        mfill += mnb;
        mleft--;
      end
      prev_stall = pop_if.valid && !pop_if.ready && !clear_i;
      prev_data  = pop_if.data;
      prev_strb  = pop_if.strb;
      if (clear_i) begin
        sb.delete();
        mfill = 0; mleft = 0; done_in = 0;
        busy_exp = 1'b0; prev_stall = 1'b0; after_clr = 1'b1;
        full_cnt = '0; part_cnt = '0;
      end else if (start_i && !busy_exp && done_in == 0) begin
        mnb = eff_nb(int'(nb_bytes_i));
        mleft = int'(nb_words_i);
        mfill = 0;
        busy_exp = 1'b1;
        if (nb_words_i == 16'd0) done_in = 2;
      end
      if (done_in == 1) busy_exp = 1'b0;
    end
  end

  task automatic rand_word(output logic [DW-1:0] d);
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
  endtask

  // Issue one tile; expected output words come from the concatenated valid-byte stream
  task automatic run_tile(input int nb_in, input int nw, input bit pat, input int vpct, input int exp_lat);
    logic [DW-1:0] beats[$];
    logic [7:0]    bq[$];
    logic [DW-1:0] d;
    logic [NB-1:0] s;
    exp_t          e;
    int            nbe, idx, t0, to;
    bit            hs, got;
    nbe = eff_nb(nb_in);
    for (int k = 0; k < nw; k++) begin
      rand_word(d);
      if (pat) for (int b = 0; b < nbe; b++) d[b*8 +: 8] = 8'((k + 1) * 17);
      beats.push_back(d);
      for (int b = 0; b < nbe; b++) bq.push_back(d[b*8 +: 8]);
    end
    idx = 0;
    while (idx < bq.size()) begin
      d = '0;
      s = '0;
      for (int b = 0; b < NB && idx < bq.size(); b++) begin
        d[b*8 +: 8] = bq[idx];
        s[b] = 1'b1;
        idx++;
      end
      e.data = d;
      e.strb = s;
      e.last = (idx == bq.size());
      sb.push_back(e);
    end
    start_i = 1'b1;
    nb_bytes_i = 6'(nb_in);
    nb_words_i = 16'(nw);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    t0 = cycle_cnt;
    foreach (beats[k]) begin
      to = 0;
      while ($urandom_range(0, 99) >= vpct && to < 8) begin
        @(posedge clk);
        #1;
        to++;
      end
      push_if.valid = 1'b1;
      push_if.data = beats[k];
      to = 0;
      hs = 1'b0;
      while (!hs && to < 2000) begin
        @(negedge clk);
        hs = push_if.ready;
        @(posedge clk);
        #1;
        to++;
      end
      chk("push_accepted", hs, 1'b1);
      push_if.valid = 1'b0;
      rand_word(d);
      push_if.data = d;
    end
    got = 1'b0;
    to = 0;
    while (!got && to < 5000) begin
      @(negedge clk);
      got = done_o;
      to++;
    end
    chk("done_seen", got, 1'b1);
    if (exp_lat > 0) chk("done_latency", cycle_cnt - t0 + 1, exp_lat);
    chk("sb_drained", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] d;
    bit hs;
    int to;
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0;
    nb_bytes_i = 6'd0; nb_words_i = 16'd0;
    push_if.valid = 1'b0; push_if.data = '0; push_if.strb = '1;
    mfill = 0; mleft = 0; mnb = 0; done_in = 0;
    busy_exp = 1'b0; prev_stall = 1'b0; after_clr = 1'b0;
    full_cnt = '0; part_cnt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", pop_if.valid, 1'b0);
    chk("rst_data", pop_if.data, '0);
    chk("rst_strb", pop_if.strb, '0);
    chk("rst_push_ready", push_if.ready, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_stats", stats_o, 64'd0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    run_tile(32, 4, 1'b0, 100, 6);
    run_tile(8, 5, 1'b1, 100, 0);
    run_tile(24, 3, 1'b0, 100, 0);
    rdy_rand = 1'b1;
    run_tile(20, 50, 1'b0, 70, 0);

    // clear while RUN with 16 bytes buffered, then restart immediately
    start_i = 1'b1; nb_bytes_i = 6'd16; nb_words_i = 16'd4;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    rand_word(d);
    push_if.valid = 1'b1;
    push_if.data = d;
    hs = 1'b0;
    to = 0;
    while (!hs && to < 100) begin
      @(negedge clk);
      hs = push_if.ready;
      @(posedge clk);
      #1;
      to++;
    end
    chk("clear_setup_push", hs, 1'b1);
    push_if.valid = 1'b0;
    clear_i = 1'b1;
    @(posedge clk);
    #1;
    clear_i = 1'b0;
    run_tile(12, 7, 1'b0, 80, 0);

    rdy_rand = 1'b0;
    run_tile(5, 0, 1'b0, 100, 2);
    rdy_rand = 1'b1;
    run_tile(0, 3, 1'b0, 100, 0);
    run_tile(40, 2, 1'b0, 100, 0);
    for (int t = 0; t < 6; t++) begin
      run_tile($urandom_range(0, 40), $urandom_range(1, 12), 1'b0, $urandom_range(50, 100), 0);
    end
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end

endmodule
